// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage that sits directly in front of the controller and
//   decoder. It owns the PC and issues one word fetch at a time over a
//   req/gnt/rvalid handshake. It can buffer one returned word while decode is
//   stalled, and it presents a registered IF/ID slot. Redirects resolved
//   downstream (taken branch, jump, jump-register) reload the PC and squash
//   any wrong-path fetch that is still in flight.
//
// Parameters
//   AW        PC / address width
//   RESET_PC  PC loaded on reset (word aligned)
//
// Ports
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   imem_req           fetch request valid
//   imem_addr          fetch byte address, always word aligned (equals pc)
//   imem_gnt           memory accepted the request this cycle
//   imem_rvalid        read data valid, one per granted request
//   imem_rdata         returned instruction word
//   pcsrc/branch_target      taken-branch redirect and its target
//   jump/jump_target         J/JAL redirect and its target
//   jumptoreg/reg_target     JR/JALR redirect and its target
//   id_ready           decode consumes the IF/ID slot this cycle
//   id_valid           IF/ID slot holds a valid instruction
//   id_instr           instruction in the slot
//   id_pcplus4         fetch address + 4 of id_instr
//   pc                 address of the next fetch to issue
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          pcsrc,
  input  logic [AW-1:0] branch_target,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  input  logic          jumptoreg,
  input  logic [AW-1:0] reg_target,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [31:0]   id_instr,
  output logic [AW-1:0] id_pcplus4,
  output logic [AW-1:0] pc
);

  localparam logic [AW-1:0] WORD_BYTES = AW'(4);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] fetch_pc;     // address of the request currently in flight
  logic          kill;         // in-flight response belongs to a wrong path
  logic          hold_valid;
  logic [31:0]   hold_instr;

  logic          redirect;
  logic [AW-1:0] raw_target;
  logic [AW-1:0] redirect_target;
  logic [AW-1:0] pc_plus4;
  logic [AW-1:0] fetch_pcplus4;
  logic          slot_free;
  logic          good_return;
  logic          load_mem;
  logic          store_hold;
  logic          load_hold;

  assign imem_addr = pc;

  // Redirect target priority: JR/JALR > J/JAL > branch; result forced word aligned
  always_comb begin
    raw_target = branch_target;
    if (jumptoreg) begin
      raw_target = reg_target;
    end else if (jump) begin
      raw_target = jump_target;
    end
  end

  assign redirect        = jumptoreg | jump | pcsrc;
  assign redirect_target = raw_target & ALIGN_MASK;

  // Both adders wrap modulo 2^AW with no carry out
  assign pc_plus4      = pc + WORD_BYTES;
  assign fetch_pcplus4 = fetch_pc + WORD_BYTES;

  // A response is usable only if it is not squashed by an old or same-cycle redirect
  assign slot_free   = !id_valid || id_ready;
  assign good_return = (state == S_WAIT) && imem_rvalid && !kill && !redirect;
  assign load_mem    = good_return && slot_free;
  assign store_hold  = good_return && !slot_free;
  assign load_hold   = (state == S_HOLD) && hold_valid && id_ready && !redirect;

  // Fetch control FSM: PC, request, kill tracking and hold buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC & ALIGN_MASK;
      imem_req   <= 1'b0;
      fetch_pc   <= '0;
      kill       <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            fetch_pc <= pc;
            imem_req <= 1'b0;
            state    <= S_WAIT;
            if (redirect) begin
              // Request already accepted: let it return, then drop it
              pc   <= redirect_target;
              kill <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end else begin
            imem_req <= !hold_valid;
            if (redirect) begin
              pc <= redirect_target;
            end
          end
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            kill <= 1'b0;
            if (redirect) begin
              pc <= redirect_target;
            end
            if (store_hold) begin
              hold_valid <= 1'b1;
              hold_instr <= imem_rdata;
              state      <= S_HOLD;
            end else begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
          end else if (redirect) begin
            pc   <= redirect_target;
            kill <= 1'b1;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            hold_valid <= 1'b0;
            pc         <= redirect_target;
            state      <= S_REQ;
            imem_req   <= 1'b1;
          end else if (id_ready) begin
            hold_valid <= 1'b0;
            state      <= S_REQ;
            imem_req   <= 1'b1;
          end
        end

        default: begin
          state    <= S_REQ;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID slot: a redirect wins over any same-cycle load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pcplus4 <= '0;
    end else if (redirect) begin
      id_valid <= 1'b0;
    end else if (load_mem) begin
      id_valid   <= 1'b1;
      id_instr   <= imem_rdata;
      id_pcplus4 <= fetch_pcplus4;
    end else if (load_hold) begin
      id_valid   <= 1'b1;
      id_instr   <= hold_instr;
      id_pcplus4 <= fetch_pcplus4;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A per-cycle vector table drives the
//   handshake/redirect inputs and holds the hand-computed outputs for that
//   cycle. Hand-written sequences cover reset in the middle of a transaction.
//   A second instance with RESET_PC=FFFF_FFFC shares the stimulus and is
//   checked for PC wrap on its first fetch.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        pcsrc = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        jumptoreg = 1'b0;
  logic [31:0] reg_target = '0;
  logic        id_ready = 1'b0;

  logic        imem_req,   w_imem_req;
  logic [31:0] imem_addr,  w_imem_addr;
  logic        id_valid,   w_id_valid;
  logic [31:0] id_instr,   w_id_instr;
  logic [31:0] id_pcplus4, w_id_pcplus4;
  logic [31:0] pc,         w_pc;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fetch_stage #(.AW(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pcsrc(pcsrc), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .jumptoreg(jumptoreg), .reg_target(reg_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pcplus4(id_pcplus4), .pc(pc)
  );

  fetch_stage #(.AW(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pcsrc(pcsrc), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .jumptoreg(jumptoreg), .reg_target(reg_target),
    .id_ready(id_ready), .id_valid(w_id_valid), .id_instr(w_id_instr),
    .id_pcplus4(w_id_pcplus4), .pc(w_pc)
  );

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        jr;
    logic        j;
    logic        br;
    logic [31:0] rtgt;
    logic [31:0] jtgt;
    logic [31:0] btgt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcp4;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                              input logic jr, input logic j, input logic br,
                              input logic [31:0] rtgt, input logic [31:0] jtgt,
                              input logic [31:0] btgt, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pcp4);
    vec_t v;
    v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
    v.jr = jr; v.j = j; v.br = br;
    v.rtgt = rtgt; v.jtgt = jtgt; v.btgt = btgt; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pcp4 = e_pcp4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pcsrc = 1'b0; jump = 1'b0; jumptoreg = 1'b0;
    branch_target = '0; jump_target = '0; reg_target = '0;
    id_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " imem_req"},   32'(imem_req),   32'h0);
    chk({tag, " imem_addr"},  imem_addr,       32'h0);
    chk({tag, " id_valid"},   32'(id_valid),   32'h0);
    chk({tag, " id_instr"},   id_instr,        32'h0);
    chk({tag, " id_pcplus4"}, id_pcplus4,      32'h0);
    chk({tag, " wrap imem_addr"}, w_imem_addr, 32'hFFFF_FFFC);
  endtask

  initial begin
    // gnt rv  rdata        jr j  br rtgt   jtgt   btgt   rdy | req addr   v  instr        pcp4
    tbl.push_back(mk(0,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h0,  0,32'h0,        32'h0));   // 0
    tbl.push_back(mk(1,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 1,32'h0,  0,32'h0,        32'h0));   // 1
    tbl.push_back(mk(0,1,32'h2009_0005,0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h4,  0,32'h0,        32'h0));   // 2
    tbl.push_back(mk(1,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 1,32'h4,  1,32'h2009_0005,32'h4));   // 3
    tbl.push_back(mk(0,1,32'h0000_0020,0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h8,  1,32'h2009_0005,32'h4));   // 4
    tbl.push_back(mk(0,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h8,  1,32'h2009_0005,32'h4));   // 5
    tbl.push_back(mk(0,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 1, 0,32'h8,  1,32'h2009_0005,32'h4));   // 6
    tbl.push_back(mk(0,0,32'h0,        1,1,1,32'h43,32'h80,32'hC0,0, 1,32'h8,  1,32'h0000_0020,32'h8));   // 7
    tbl.push_back(mk(1,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 1,32'h40, 0,32'h0000_0020,32'h8));   // 8
    tbl.push_back(mk(0,0,32'h0,        0,0,1,32'h0, 32'h0, 32'h100,0,0,32'h44, 0,32'h0000_0020,32'h8));   // 9
    tbl.push_back(mk(0,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h100,0,32'h0000_0020,32'h8));   // 10
    tbl.push_back(mk(0,1,32'hDEAD_BEEF,0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h100,0,32'h0000_0020,32'h8));   // 11
    tbl.push_back(mk(1,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 1,32'h100,0,32'h0000_0020,32'h8));   // 12
    tbl.push_back(mk(0,1,32'h8C08_0000,0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h104,0,32'h0000_0020,32'h8));   // 13
    tbl.push_back(mk(0,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 1, 1,32'h104,1,32'h8C08_0000,32'h104)); // 14
    tbl.push_back(mk(1,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 1,32'h104,0,32'h8C08_0000,32'h104)); // 15
    tbl.push_back(mk(0,1,32'h1111_1111,0,1,0,32'h0, 32'h200,32'h0,0, 0,32'h108,0,32'h8C08_0000,32'h104)); // 16
    tbl.push_back(mk(1,0,32'h0,        0,0,1,32'h0, 32'h0, 32'h300,0,1,32'h200,0,32'h8C08_0000,32'h104)); // 17
    tbl.push_back(mk(0,1,32'h2222_2222,0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h300,0,32'h8C08_0000,32'h104)); // 18
    tbl.push_back(mk(1,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 1,32'h300,0,32'h8C08_0000,32'h104)); // 19
    tbl.push_back(mk(0,1,32'hAAAA_0001,0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h304,0,32'h8C08_0000,32'h104)); // 20
    tbl.push_back(mk(1,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 1,32'h304,1,32'hAAAA_0001,32'h304)); // 21
    tbl.push_back(mk(0,1,32'hBBBB_0002,0,0,0,32'h0, 32'h0, 32'h0, 0, 0,32'h308,1,32'hAAAA_0001,32'h304)); // 22
    tbl.push_back(mk(0,0,32'h0,        0,1,0,32'h0, 32'h502,32'h0,1, 0,32'h308,1,32'hAAAA_0001,32'h304)); // 23
    tbl.push_back(mk(0,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 1,32'h500,0,32'hAAAA_0001,32'h304)); // 24
    tbl.push_back(mk(0,0,32'h0,        0,0,0,32'h0, 32'h0, 32'h0, 0, 1,32'h500,0,32'hAAAA_0001,32'h304)); // 25

    drive_idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // Each row: outputs observed during the cycle, then that cycle's inputs
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("c%0d imem_req", i),   32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("c%0d imem_addr", i),  imem_addr,     tbl[i].e_addr);
      chk($sformatf("c%0d id_valid", i),   32'(id_valid), 32'(tbl[i].e_valid));
      chk($sformatf("c%0d id_instr", i),   id_instr,      tbl[i].e_instr);
      chk($sformatf("c%0d id_pcplus4", i), id_pcplus4,    tbl[i].e_pcp4);
      if (i == 1) chk("wrap first imem_addr", w_imem_addr, 32'hFFFF_FFFC);
      if (i == 3) begin
        chk("wrap id_pcplus4", w_id_pcplus4, 32'h0);
        chk("wrap next imem_addr", w_imem_addr, 32'h0);
        chk("wrap id_valid", 32'(w_id_valid), 32'h1);
      end
      imem_gnt      = tbl[i].gnt;
      imem_rvalid   = tbl[i].rvalid;
      imem_rdata    = tbl[i].rdata;
      jumptoreg     = tbl[i].jr;
      jump          = tbl[i].j;
      pcsrc         = tbl[i].br;
      reg_target    = tbl[i].rtgt;
      jump_target   = tbl[i].jtgt;
      branch_target = tbl[i].btgt;
      id_ready      = tbl[i].rdy;
      @(negedge clk);
    end

    // Reset asserted while a request is outstanding
    drive_idle();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("pre-reset imem_req", 32'(imem_req), 32'h0);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async reset");
    @(negedge clk);
    @(negedge clk);

    // Release with a stray response that must be ignored
    reset_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h3333_3333;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("post-reset imem_req",   32'(imem_req), 32'h1);
    chk("post-reset imem_addr",  imem_addr,     32'h0);
    chk("post-reset id_valid",   32'(id_valid), 32'h0);
    chk("post-reset id_instr",   id_instr,      32'h0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("post-reset wait imem_req", 32'(imem_req), 32'h0);
    chk("post-reset wait imem_addr", imem_addr, 32'h4);
    chk("post-reset wait id_valid", 32'(id_valid), 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h4444_4444;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("post-reset id_valid load", 32'(id_valid), 32'h1);
    chk("post-reset id_instr load", id_instr,      32'h4444_4444);
    chk("post-reset id_pcplus4",    id_pcplus4,    32'h4);
    chk("post-reset next imem_req", 32'(imem_req), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the main controller/decoder.
- Owns the PC, issues word fetches to instruction memory over a req/gnt/rvalid handshake, and buffers returned words.
- Presents a registered IF/ID slot (instruction plus PC+4) whose op/funct fields feed the controller.
- Accepts redirects (branch, jump, jump-register) resolved downstream and flushes wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
- AW, 32, PC/address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  AW  fetch word address (byte address, [1:0]=00).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid (exactly one per granted request, ≥1 cycle after gnt).
- imem_rdata  in  32  instruction word.
- pcsrc  in  1  taken branch redirect.
- branch_target  in  AW  branch target.
- jump  in  1  J/JAL redirect.
- jump_target  in  AW  jump target.
- jumptoreg  in  1  JR/JALR redirect.
- reg_target  in  AW  register target.
- id_ready  in  1  decode consumes the IF/ID slot this cycle.
- id_valid  out  1  IF/ID slot holds a valid instruction.
- id_instr  out  32  instruction; [31:26]=op, [5:0]=funct to controller.
- id_pcplus4  out  AW  fetch address + 4 of id_instr.
- pc  out  AW  address of the next fetch to issue.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - pc=RESET_PC, imem_req=0, id_valid=0, id_instr=0, id_pcplus4=0.
  - Hold buffer empty, kill flag clear, FSM=REQ.
- Redirect:
  - redirect = jumptoreg|jump|pcsrc.
  - Target priority: jumptoreg (reg_target) > jump (jump_target) > pcsrc (branch_target).
  - Target bits [1:0] are forced to 00.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req=1 when the hold buffer is empty; imem_addr=pc.
  - On gnt: latch the in-flight PC, set pc=pc+4, go to WAIT.
  - Redirect without gnt: pc=target, stay in REQ; the new address is presented next cycle.
  - Redirect with gnt in the same cycle: pc=target, set kill, go to WAIT.
- WAIT:
  - imem_req=0. Only one request is outstanding.
  - On rvalid with kill set: discard data, clear kill, go to REQ.
  - On rvalid with kill clear: if the slot is free (id_valid=0 or id_ready=1), load the slot and go to REQ; otherwise store in the hold buffer and go to HOLD.
  - Redirect in WAIT: pc=target, set kill.
  - Redirect in the same cycle as rvalid: the data is discarded.
- HOLD:
  - imem_req=0.
  - When id_ready=1: move the buffer into the slot and go to REQ.
  - Redirect: clear the buffer, go to REQ with pc=target.
- IF/ID slot:
  - Slot load sets id_valid=1, id_instr=rdata (or buffer), id_pcplus4=fetch_pc+4.
  - id_ready with no load clears id_valid.
  - Any redirect clears id_valid next cycle; redirect wins over a same-cycle load.
- Latency:
  - gnt at cycle t, rvalid at t+k: id_valid=1 at t+k+1.
  - Next imem_req rises at t+k+1.
- Wrap: pc+4 wraps modulo 2^AW with no flag. 32'hFFFF_FFFC+4 gives 0.
- Reset mid-transaction: all state clears immediately. A late rvalid arriving after reset release while in REQ is ignored; rvalid is only sampled in WAIT.
- id_ready while id_valid=0 has no effect.

Test Plan:
- Reset release, gnt same cycle, rvalid 1 cycle later with 32'h2009_0005 -> imem_addr=0, then id_valid=1, id_instr=32'h2009_0005, id_pcplus4=4, next imem_addr=4.
- Back-to-back fetch with id_ready=0 for 3 cycles, second rvalid=32'h0000_0020 -> enters HOLD, imem_req=0; after id_ready=1 the slot shows 32'h0000_0020 with id_pcplus4=8.
- jumptoreg=1 (reg_target=32'h40), jump=1 (jump_target=32'h80), pcsrc=1 in the same cycle in REQ -> next imem_addr=32'h40, id_valid=0.
- pcsrc=1, branch_target=32'h100 while in WAIT; rvalid=32'hDEAD_BEEF arrives 2 cycles later -> data discarded, id_valid stays 0, next request at 32'h100, id_pcplus4=32'h104 on return.
- reset_n low during WAIT, then released with a stray rvalid -> outputs at reset values, stray data ignored, first request at RESET_PC.
- RESET_PC=32'hFFFF_FFFC, one fetch -> id_pcplus4=0, next imem_addr=0.
